dmem_arbiter: RTL

- Shares the single-port data RAM between the core's MEM stage and one secondary bus master, such as a DMA or peripheral engine.
- Sits between the core's ram_addr/ram_wdata/ram_we/ram_rdata port and the physical data RAM.
- The core has default priority. A starvation counter guarantees the secondary master forward progress.
- A lockable burst mode lets the secondary master hold the RAM for up to BURST_MAX beats.
- cpu_stall feeds the pipeline control unit so PC, IF/ID, ID/EX, EX/MEM and MEM/WB freeze while the core is denied.

---
 rtl/dmem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core MEM stage and one secondary master (core-first, starvation-bounded, lockable bursts).
// Latency 0: reads return in the grant cycle; backpressure via cpu_stall_o to the core and dma_gnt_o to the secondary master.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    input  logic              dma_last_i,
    output logic              dma_gnt_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_rvalid_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
    localparam logic [3:0] BEAT_LAST_C = 4'(BURST_MAX - 1);
    localparam logic       SINGLE_BEAT = (BURST_MAX == 1);

    logic [0:0] state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       dma_own, core_own, gnt, stall;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_cnt_d = beat_cnt_q;
        dma_own    = 1'b0;
        core_own   = 1'b0;
        gnt        = 1'b0;
        stall      = 1'b0;
        if (state_q == ST_LOCK) begin
            dma_own = 1'b1;
            gnt     = dma_req_i;
            stall   = cpu_req_i;
            // Dropping the request releases the lock without consuming a beat.
            if (!dma_req_i || dma_last_i || (beat_cnt_q == BEAT_LAST_C)) begin
                state_d    = ST_ARB;
                wait_cnt_d = 4'd0;
                beat_cnt_d = 4'd0;
            end else begin
                beat_cnt_d = beat_cnt_q + 4'd1;
            end
        end else if (dma_req_i && (!cpu_req_i || (wait_cnt_q == MAX_WAIT_C))) begin
            dma_own    = 1'b1;
            gnt        = 1'b1;
            stall      = cpu_req_i;
            wait_cnt_d = 4'd0;
            beat_cnt_d = 4'd1;
            state_d    = (dma_last_i || SINGLE_BEAT) ? ST_ARB : ST_LOCK;
        end else if (cpu_req_i) begin
            core_own   = 1'b1;
            // Cannot pass MAX_WAIT: at MAX_WAIT the branch above wins instead.
            wait_cnt_d = dma_req_i ? (wait_cnt_q + 4'd1) : 4'd0;
        end else begin
            wait_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ARB;
            wait_cnt_q <= 4'd0;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Handshakes are gated by reset so an in-flight write dies the instant reset falls.
    assign cpu_stall_o  = rst_ni & stall;
    assign dma_gnt_o    = rst_ni & gnt;
    assign dma_rvalid_o = rst_ni & gnt & ~dma_we_i;
    assign ram_we_o     = rst_ni & (dma_own ? (dma_we_i & gnt) : (core_own & cpu_we_i));
    assign ram_addr_o   = dma_own ? dma_addr_i  : cpu_addr_i;
    assign ram_wdata_o  = dma_own ? dma_wdata_i : cpu_wdata_i;
    assign cpu_rdata_o  = ram_rdata_i;
    assign dma_rdata_o  = ram_rdata_i;

endmodule
